// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the pipeline run monitor: run state, log entry
// layout and the default widths the monitor is built around.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } run_state_e;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_CNT_W     = 32;
  localparam int DEF_LOG_DEPTH = 16;
  localparam int LOG_LEVEL_W   = $clog2(DEF_LOG_DEPTH) + 1;

  // Field order matches the packed vector the monitor pushes into its log FIFO.
  typedef struct packed {
    logic [DEF_CNT_W-1:0]  cycle;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } log_entry_t;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/monitor_log_fifo.sv
// Synchronous store-log FIFO without bypass; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle, otherwise it is reported as a drop.
module monitor_log_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             pop_ok_s, push_ok_s;

  assign empty_o   = (level_q == '0);
  assign full_o    = (level_q == FULL_LVL);
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign drop_o    = push_i && full_o && !pop_ok_s;
  assign level_o   = level_q;
  // Head is forced to zero while empty so stale storage never leaks out.
  assign data_o    = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/pipeline_run_monitor.sv
// Run monitor beside the pipelined core: counts cycles, logs stores, detects
// the done store (pass/fail), flags timeout and emits a periodic heartbeat.
module pipeline_run_monitor
  import run_monitor_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                CNT_W      = 32,
  parameter int                LOG_DEPTH  = 16,
  parameter int                MAX_CYCLES = 500,
  parameter int                HB_PERIOD  = 10,
  parameter logic [ADDR_W-1:0] DONE_ADDR  = 32'h0000_0064,
  parameter logic [DATA_W-1:0] PASS_VALUE = 32'd25
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [ADDR_W-1:0]          DataAdr,
  input  logic [DATA_W-1:0]          WriteData,
  output logic                       log_valid,
  input  logic                       log_ready,
  output logic [CNT_W-1:0]           log_cycle,
  output logic [ADDR_W-1:0]          log_addr,
  output logic [DATA_W-1:0]          log_data,
  output logic [$clog2(LOG_DEPTH):0] log_level,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           store_count,
  output logic                       heartbeat,
  output logic                       halted,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic                       overflow
);

  localparam int               ENT_W   = CNT_W + ADDR_W + DATA_W;
  localparam int               HB_W    = $clog2(HB_PERIOD);
  localparam logic [HB_W-1:0]  HB_LAST = HB_W'(HB_PERIOD - 1);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);

  run_state_e       state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, stores_q, stores_d;
  logic [CNT_W-1:0] cycle_inc_s, stores_inc_s;
  logic [HB_W-1:0]  hb_q, hb_d;
  logic             hb_pulse_q, hb_pulse_d;
  logic             pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
  logic             overflow_q, overflow_d;
  logic             push_s, drop_s, full_s, empty_s, done_s;
  logic [ENT_W-1:0] head_s;

  // Counters saturate at all-ones instead of wrapping.
  assign cycle_inc_s  = (cycle_q  == {CNT_W{1'b1}}) ? cycle_q  : cycle_q  + CNT_W'(1);
  assign stores_inc_s = (stores_q == {CNT_W{1'b1}}) ? stores_q : stores_q + CNT_W'(1);
  assign done_s       = MemWrite && (DataAdr == DONE_ADDR);

  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    stores_d   = stores_q;
    hb_d       = hb_q;
    hb_pulse_d = 1'b0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    push_s     = 1'b0;
    case (state_q)
      ST_RUN: begin
        cycle_d = cycle_inc_s;
        hb_d    = (hb_q == HB_LAST) ? '0 : hb_q + HB_W'(1);
        if (MemWrite) begin
          stores_d = stores_inc_s;
          push_s   = 1'b1;
        end else begin
          stores_d = stores_q;
        end
        // A done store on the limit cycle takes precedence over timeout.
        if (done_s) begin
          state_d = ST_DONE;
          pass_d  = (WriteData == PASS_VALUE);
          fail_d  = (WriteData != PASS_VALUE);
        end else if (cycle_inc_s == MAX_C) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end else begin
          hb_pulse_d = (hb_q == HB_LAST);
        end
      end
      ST_DONE, ST_TIMEOUT: state_d = state_q;
      default:             state_d = ST_RUN;
    endcase
  end

  assign overflow_d = overflow_q || drop_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      cycle_q    <= '0;
      stores_q   <= '0;
      hb_q       <= '0;
      hb_pulse_q <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      stores_q   <= stores_d;
      hb_q       <= hb_d;
      hb_pulse_q <= hb_pulse_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

  monitor_log_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push_s),
    .data_i  ({cycle_inc_s, DataAdr, WriteData}),
    .pop_i   (log_ready),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (log_level),
    .drop_o  (drop_s)
  );

  assign log_valid   = !empty_s;
  assign {log_cycle, log_addr, log_data} = head_s;
  assign cycle_count = cycle_q;
  assign store_count = stores_q;
  assign heartbeat   = hb_pulse_q;
  assign halted      = (state_q != ST_RUN);
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;

  logic unused_full_s;
  assign unused_full_s = full_s;

endmodule
